// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, line levels and field decoders for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {NONE, ODD, EVEN, MARK, SPACE} parity_e;
    typedef enum logic [1:0] {ONE, ONE_HALF, TWO} stop_e;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_BREAK = 1'b0;

    function automatic parity_e parity_decode(input logic [2:0] field);
        parity_e p;
        case (field)
            3'b001:  p = ODD;
            3'b011:  p = EVEN;
            3'b101:  p = MARK;
            3'b111:  p = SPACE;
            default: p = NONE;
        endcase
        return p;
    endfunction

    function automatic stop_e stop_decode(input logic [1:0] field);
        return field[1] ? TWO : (field[0] ? ONE_HALF : ONE);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - character write port of the UART transmitter
interface uart_tx_frame_if #(
    parameter int DATA_MAX = 9
);
    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_MAX-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous character queue, flushed by rst or clear
module uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [LW-1:0]    count;
    logic             do_push, do_pop;

    // A full queue refuses a push even when a pop frees a slot in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    assign pop_data = mem[rptr];
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - programmable-frame UART transmitter with CTS flow control and break
// UART_TX_FIFO_EN selects a FIFO_DEPTH-entry queue; otherwise a single holding register is used
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_MAX   = 9,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            baud_ce,
    uart_tx_frame_if.slave                  wr,
    input  logic [3:0]                      word_len,
    input  logic [2:0]                      parity,
    input  logic [1:0]                      stop_bits,
    input  logic                            tx_break,
    input  logic                            cts,
    output logic                            txd,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);
    localparam int TKW = $clog2(2 * OVS);
    localparam logic [TKW-1:0] T_ONE  = TKW'(OVS - 1);
    localparam logic [TKW-1:0] T_HALF = TKW'(3 * OVS / 2 - 1);
    localparam logic [TKW-1:0] T_TWO  = TKW'(2 * OVS - 1);

    tx_state_e           state, state_n;
    logic [TKW-1:0]      tk, tk_n, stop_end;
    logic [3:0]          bit_idx, bit_n, len_q, len_eff;
    logic                brk_stop, brk_stop_n, fd_n, txd_n, par_bit, pop;
    logic [DATA_MAX-1:0] data_q, q_data;
    parity_e             par_q;
    stop_e               stop_q;

    assign wr.wr_ready = ~full;
    assign busy        = (state != IDLE);
    assign pop         = (state == IDLE) && baud_ce && !tx_break && !empty && cts && !clear && !rst;
    assign len_eff     = (word_len < 4'd5 || word_len > 4'(DATA_MAX)) ? 4'(DATA_MAX) : word_len;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(.WIDTH(DATA_MAX), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .clear(clear),
        .push(wr.wr_valid), .push_data(wr.wr_data),
        .pop(pop), .pop_data(q_data),
        .full(full), .empty(empty), .level(level)
    );
`else
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    logic hold_valid;

    always_ff @(posedge clk) begin
        if (rst || clear)                       hold_valid <= 1'b0;
        else if (wr.wr_valid && !hold_valid)    hold_valid <= 1'b1;
        else if (pop)                           hold_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr.wr_valid && !hold_valid) q_data <= wr.wr_data;
    end

    assign empty = ~hold_valid;
    assign full  = hold_valid;
    assign level = LW'(hold_valid);
`endif

    // Frame settings are frozen at pop so later config writes never disturb a frame on the line
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= 4'(DATA_MAX);
            par_q  <= NONE;
            stop_q <= ONE;
            data_q <= '0;
        end else if (pop) begin
            len_q  <= len_eff;
            par_q  <= parity_decode(parity);
            stop_q <= stop_decode(stop_bits);
            data_q <= q_data & DATA_MAX'((32'd1 << len_eff) - 32'd1);
        end
    end

    always_comb begin
        par_bit = 1'b0;
        case (par_q)
            ODD:     par_bit = ~^data_q;
            EVEN:    par_bit = ^data_q;
            MARK:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    // The mark period after a break is always one bit, independent of the latched stop setting
    always_comb begin
        stop_end = T_ONE;
        if (!brk_stop) begin
            case (stop_q)
                ONE_HALF: stop_end = T_HALF;
                TWO:      stop_end = T_TWO;
                default:  stop_end = T_ONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            tk         <= '0;
            bit_idx    <= '0;
            brk_stop   <= 1'b0;
            txd        <= LINE_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            tk         <= tk_n;
            bit_idx    <= bit_n;
            brk_stop   <= brk_stop_n;
            txd        <= txd_n;
            frame_done <= fd_n;
        end
    end

    always_comb begin
        state_n    = state;
        tk_n       = tk;
        bit_n      = bit_idx;
        brk_stop_n = brk_stop;
        fd_n       = 1'b0;
        if (baud_ce) begin
            case (state)
                IDLE: begin
                    tk_n = '0;
                    if (tx_break)  state_n = BREAK;
                    else if (pop)  state_n = START;
                end
                START: begin
                    if (tk == T_ONE) begin
                        state_n = DATA;
                        tk_n    = '0;
                        bit_n   = '0;
                    end else tk_n = tk + TKW'(1);
                end
                DATA: begin
                    if (tk == T_ONE) begin
                        tk_n = '0;
                        if (bit_idx == len_q - 4'd1) state_n = (par_q == NONE) ? STOP : PARITY;
                        else                         bit_n   = bit_idx + 4'd1;
                    end else tk_n = tk + TKW'(1);
                end
                PARITY: begin
                    if (tk == T_ONE) begin
                        state_n = STOP;
                        tk_n    = '0;
                    end else tk_n = tk + TKW'(1);
                end
                STOP: begin
                    if (tk == stop_end) begin
                        state_n    = IDLE;
                        tk_n       = '0;
                        fd_n       = ~brk_stop;
                        brk_stop_n = 1'b0;
                    end else tk_n = tk + TKW'(1);
                end
                BREAK: begin
                    if (!tx_break) begin
                        state_n    = STOP;
                        tk_n       = '0;
                        brk_stop_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // txd is registered from the next-state view so it moves one clk after the entering baud_ce
    always_comb begin
        txd_n = LINE_IDLE;
        case (state_n)
            START, BREAK: txd_n = LINE_BREAK;
            DATA:         txd_n = data_q[bit_n];
            PARITY:       txd_n = par_bit;
            default:      txd_n = LINE_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame against a tick-waveform model
module tb_uart_tx_frame;
    localparam int DATA_MAX   = 9;
    localparam int OVS        = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);
`ifdef UART_TX_FIFO_EN
    localparam int QDEPTH = FIFO_DEPTH;
`else
    localparam int QDEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst, clear, baud_ce, tx_break, cts;
    logic [3:0] word_len;
    logic [2:0] parity;
    logic [1:0] stop_bits;
    logic txd, busy, frame_done, empty, full;
    logic [LW-1:0] level;

    uart_tx_frame_if #(.DATA_MAX(DATA_MAX)) wr_if ();

    uart_tx_frame #(.DATA_MAX(DATA_MAX), .OVS(OVS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .baud_ce(baud_ce), .wr(wr_if),
        .word_len(word_len), .parity(parity), .stop_bits(stop_bits),
        .tx_break(tx_break), .cts(cts), .txd(txd), .busy(busy),
        .frame_done(frame_done), .empty(empty), .full(full), .level(level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;
    int ce_pct   = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queued characters plus the per-tick line value of the frame being sent
    logic [DATA_MAX-1:0] mq[$];
    bit m_wave[$];
    bit m_busy = 0, m_brk = 0, m_txd = 1, m_done = 0, m_with_done = 0;
    int m_pos = 0;
    bit m_push, m_pop;

    function automatic void build_frame(input logic [DATA_MAX-1:0] d);
        int len, np, stop_ticks;
        bit pb;
        logic [DATA_MAX-1:0] md;
        len = (word_len >= 5 && word_len <= DATA_MAX) ? int'(word_len) : DATA_MAX;
        md  = d & DATA_MAX'((1 << len) - 1);
        np  = 1;
        pb  = 0;
        case (parity)
            3'b001:  pb = ~^md;
            3'b011:  pb = ^md;
            3'b101:  pb = 1;
            3'b111:  pb = 0;
            default: np = 0;
        endcase
        stop_ticks = (stop_bits == 2'b00) ? OVS : (stop_bits == 2'b01) ? (3 * OVS / 2) : 2 * OVS;
        m_wave.delete();
        repeat (OVS) m_wave.push_back(1'b0);
        for (int i = 0; i < len; i++) repeat (OVS) m_wave.push_back(md[i]);
        if (np != 0) repeat (OVS) m_wave.push_back(pb);
        repeat (stop_ticks) m_wave.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        m_done = 0;
        if (rst || clear) begin
            mq.delete();
            m_wave.delete();
            m_busy = 0;
            m_brk  = 0;
            m_txd  = 1;
        end else begin
            m_push = wr_if.wr_valid && (mq.size() < QDEPTH);
            m_pop  = 0;
            if (baud_ce) begin
                if (m_brk) begin
                    if (!tx_break) begin
                        m_brk = 0;
                        m_wave.delete();
                        repeat (OVS) m_wave.push_back(1'b1);
                        m_pos = 0;
                        m_with_done = 0;
                        m_txd = 1;
                    end
                end else if (m_busy) begin
                    m_pos++;
                    if (m_pos == m_wave.size()) begin
                        m_busy = 0;
                        m_txd  = 1;
                        m_done = m_with_done;
                    end else m_txd = m_wave[m_pos];
                end else if (tx_break) begin
                    m_brk  = 1;
                    m_busy = 1;
                    m_txd  = 0;
                end else if (mq.size() > 0 && cts) begin
                    m_pop = 1;
                    build_frame(mq[0]);
                    m_pos = 0;
                    m_busy = 1;
                    m_with_done = 1;
                    m_txd = m_wave[0];
                end
            end
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(wr_if.wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("txd", txd, m_txd);
            chk("busy", busy, m_busy);
            chk("frame_done", frame_done, m_done);
            chk("level", level, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == QDEPTH);
            chk("wr_ready", wr_if.wr_ready, mq.size() != QDEPTH);
        end
    end

    initial begin
        baud_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            baud_ce = ($urandom_range(0, 99) < ce_pct);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [DATA_MAX-1:0] d);
        int g = 0;
        while (!wr_if.wr_ready && g < 5000) begin step(1); g++; end
        chk("write_ready_timeout", wr_if.wr_ready, 1'b1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        step(1);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int g = 0;
        while (!(empty && !busy) && g < limit) begin step(1); g++; end
        chk("idle_timeout", (empty && !busy), 1'b1);
    endtask

    task automatic wait_done(input int limit);
        int g = 0;
        while (!frame_done && g < limit) begin step(1); g++; end
        chk("done_timeout", frame_done, 1'b1);
        step(1);
    endtask

    logic cap [0:511];
    int cap_done;

    task automatic capture_frame();
        int g = 0;
        while (!busy && g < 2000) begin step(1); g++; end
        chk("frame_start_timeout", busy, 1'b1);
        cap_done = -1;
        for (int t = 0; t < 512; t++) begin
            cap[t] = txd;
            if (frame_done) begin
                cap_done = t;
                break;
            end
            step(1);
        end
    endtask

    logic [0:10] a5_exp;
    int ones;

    initial begin
        rst = 1; clear = 0; cts = 1; tx_break = 0;
        word_len = 4'd8; parity = 3'b000; stop_bits = 2'b00;
        wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
        step(1);
        chk_en = 1;
        step(2);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_wr_ready", wr_if.wr_ready, 1'b1);
        chk("rst_frame_done", frame_done, 1'b0);
        rst = 0;
        step(2);

        // 8E1 0xA5: start, 1,0,1,0,0,1,0,1, parity 0, stop 1
        a5_exp = 11'b01010010101;
        word_len = 4'd8; parity = 3'b011; stop_bits = 2'b00;
        write_char(9'h0A5);
        capture_frame();
        chk("a5_frame_ticks", cap_done, 176);
        for (int k = 0; k < 11; k++) chk($sformatf("a5_bit%0d", k), cap[8 + 16 * k], a5_exp[k]);
        step(3);

        // 5N1.5 0x1F: 120 ticks, mark for the last 24
        word_len = 4'd5; parity = 3'b000; stop_bits = 2'b01;
        write_char(9'h01F);
        capture_frame();
        chk("w5_frame_ticks", cap_done, 120);
        chk("w5_start", cap[8], 1'b0);
        ones = 0;
        for (int t = 96; t < 120; t++) ones += int'(cap[t]);
        chk("w5_stop_mark", ones, 24);
        step(3);

        // CTS hold, release, and drop mid-frame
        word_len = 4'd8; parity = 3'b000; stop_bits = 2'b00;
        cts = 0;
`ifdef UART_TX_FIFO_EN
        for (int i = 0; i < 3; i++) write_char(DATA_MAX'($urandom));
        step(40);
        chk("cts_hold_level", level, 3);
        chk("cts_hold_txd", txd, 1'b1);
        cts = 1;
        wait_done(2000);
        step(20);
        cts = 0;
        wait_done(2000);
        step(100);
        chk("cts_stall_level", level, 1);
        chk("cts_stall_busy", busy, 1'b0);
`else
        write_char(DATA_MAX'($urandom));
        step(40);
        chk("cts_hold_level", level, 1);
        chk("cts_hold_txd", txd, 1'b1);
`endif
        cts = 1;
        wait_idle(5000);

        // Fill the queue, offer one more, then drain in order
        cts = 0;
        for (int i = 0; i < QDEPTH; i++) write_char(DATA_MAX'($urandom));
        chk("fill_full", full, 1'b1);
        chk("fill_wr_ready", wr_if.wr_ready, 1'b0);
        chk("fill_level", level, QDEPTH);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = DATA_MAX'($urandom);
        step(3);
        wr_if.wr_valid = 1'b0;
        chk("overfill_level", level, QDEPTH);
        cts = 1;
        wait_idle(QDEPTH * 400 + 1000);

        // Break requested mid-frame
        word_len = 4'd7; parity = 3'b001; stop_bits = 2'b10;
        write_char(DATA_MAX'($urandom));
        write_char(DATA_MAX'($urandom));
        step(30);
        tx_break = 1;
        wait_done(2000);
        step(40);
        chk("break_txd", txd, 1'b0);
        chk("break_busy", busy, 1'b1);
        tx_break = 0;
        wait_idle(3000);

        // clear, then rst, during DATA
        word_len = 4'd8; parity = 3'b000; stop_bits = 2'b00;
        for (int r = 0; r < 2; r++) begin
            write_char(DATA_MAX'($urandom));
            write_char(DATA_MAX'($urandom));
            step(40);
            if (r == 0) clear = 1; else rst = 1;
            step(1);
            clear = 0;
            rst = 0;
            chk($sformatf("abort%0d_txd", r), txd, 1'b1);
            chk($sformatf("abort%0d_busy", r), busy, 1'b0);
            chk($sformatf("abort%0d_level", r), level, 0);
            chk($sformatf("abort%0d_empty", r), empty, 1'b1);
            step(5);
        end

        // Randomised traffic with mid-frame config, cts, break and clear activity
        ce_pct = 40;
        for (int it = 0; it < 25; it++) begin
            word_len  = 4'($urandom);
            parity    = 3'($urandom);
            stop_bits = 2'($urandom);
            for (int c = 0; c < 300; c++) begin
                wr_if.wr_valid = ($urandom_range(0, 9) < 3);
                wr_if.wr_data  = DATA_MAX'($urandom);
                if ($urandom_range(0, 49) == 0) cts = ~cts;
                if (c == 150 && (it % 6) == 5) tx_break = 1;
                if (c == 200) tx_break = 0;
                clear = ($urandom_range(0, 999) == 0);
                if ($urandom_range(0, 99) == 0) word_len = 4'($urandom);
                step(1);
            end
        end
        wr_if.wr_valid = 1'b0;
        clear = 0;
        tx_break = 0;
        cts = 1;
        wait_idle(40000);
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the serial controller. It takes characters over a valid/ready write port, queues them in an optional FIFO, and serialises them on `txd` with a programmable frame: 5..DATA_MAX data bits, parity, 1/1.5/2 stop bits, CTS flow control and break. It replaces the fixed 8-bit, fixed-16x transmitter and adds back-pressure, configurable oversampling and fractional stop bits.

## Interface
Parameters:
- DATA_MAX, 9: maximum data bits per character (5..9).
- OVS, 16: baud_ce ticks per bit time; even, 8..32.
- FIFO_DEPTH, 16: queue entries; power of two, at least 2.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous abort: idle line, flush queue
- baud_ce  in  1  oversample clock enable
- wr_valid  in  1  character offered
- wr_ready  out  1  character accepted when wr_valid & wr_ready
- wr_data  in  DATA_MAX  character, LSB first on the line
- word_len  in  4  data bits; values outside 5..DATA_MAX are treated as DATA_MAX
- parity  in  3  001 odd, 011 even, 101 mark, 111 space, others none
- stop_bits  in  2  00 one, 01 one-and-a-half, 1x two
- tx_break  in  1  request break (line held low)
- cts  in  1  clear to send, active-high
- txd  out  1  serial output, registered
- busy  out  1  state other than IDLE
- frame_done  out  1  one-clk pulse at the end of the last stop bit
- empty  out  1  queue empty
- full  out  1  queue full
- level  out  $clog2(FIFO_DEPTH+1)  characters queued

## Operation
- Reset and clear values: txd=1, busy=0, frame_done=0, empty=1, full=0, level=0, wr_ready=1, state IDLE, counters 0.
- wr_ready = ~full. A write to a full queue is not accepted, even if a pop occurs in the same cycle.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Per-bit timing: a tick counter `tk` advances on baud_ce only. A bit ends when tk reaches OVS-1. The final stop period ends at 3*OVS/2-1 for 1.5 stop bits.
- IDLE, on baud_ce:
  - If tx_break is high, go to BREAK.
  - Otherwise, if the queue is not empty and cts is high, pop one character and go to START.
  - On a pop, latch word_len, parity and stop_bits, and latch the data masked to word_len. Later config changes never affect a frame in progress.
- START sends 0. DATA sends latched bits LSB first, for word_len bits.
- PARITY is entered only when parity is enabled:
  - odd: ~^data; even: ^data; mark: 1; space: 0.
- STOP sends 1 for 1, 1.5 or 2 bit times, then pulses frame_done and returns to IDLE.
- cts is sampled only in IDLE. Deasserting it mid-frame never truncates the frame.
- tx_break raised mid-frame takes effect only after STOP completes.
- BREAK holds txd=0 while tx_break is high. When tx_break falls, the block sends one bit time of mark (STOP, one bit, with no frame_done pulse) before returning to IDLE.
- clear overrides all other activity in the same cycle. rst mid-frame behaves identically to clear, and also resets any latched configuration.
- Simultaneous write and pop on a non-full queue: level is unchanged, and data stays in order.

## Timing
- txd is registered. It changes exactly 1 clk after the baud_ce that enters a new state or bit.
- A write accepted at cycle N is visible to IDLE at cycle N+1. The frame starts on the first baud_ce at or after N+1 with cts high.
- Frame length in baud_ce ticks: OVS*(1 + word_len + p + s), where p is 0 or 1 for parity and s is 1, 1.5 or 2 stop bits.
- level, empty and full update 1 clk after a push or pop.

## Configuration
- UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry queue is instantiated.
- UART_TX_FIFO_EN undefined: a single holding register replaces the queue, with full = ~empty and level in {0,1}. FIFO_DEPTH is ignored. All frame behaviour is identical.

## Structure
- Package uart_pkg holds:
  - parity_e (NONE, ODD, EVEN, MARK, SPACE) and its decode from the 3-bit field;
  - stop_e (ONE, ONE_HALF, TWO);
  - tx_state_e;
  - constant values for the line idle level and break level.
- Sub-module uart_tx_fifo is a synchronous FIFO parametrised by width and depth, providing push, pop, full, empty and level. It is flushed by rst|clear.

## Test plan
- OVS=16, word_len=8, even parity, 1 stop, write 0xA5:
  - txd is 0 (start) for 16 ticks;
  - then data bits 1,0,1,0,0,1,0,1, 16 ticks each;
  - then parity 0, then stop 1;
  - total 176 ticks, with frame_done pulsing once.
- word_len=5, no parity, stop_bits=01, write 0x1F: frame lasts 16*(1+5)+24 = 120 ticks, with txd=1 during the last 24.
- cts low with 3 characters queued: txd stays 1 and level stays 3. Raise cts: the 3 frames go back to back. Dropping cts mid-frame 2 finishes frame 2 and then stalls.
- Fill FIFO_DEPTH=16 entries: full=1 and wr_ready=0, and a 17th write is ignored. Then drain the queue and check all 16 characters are sent in order.
- tx_break asserted mid-frame: the current frame completes, then txd=0 while tx_break is high. After release, txd=1 for 16 ticks with no frame_done pulse, then the next queued frame starts.
- clear pulsed during DATA: the next clk gives txd=1, busy=0, level=0 and empty=1. Repeat with rst and expect the same outputs.
